// File: rtl/soc_h2f_cmd_pkg.sv
// Shared constants for the HPS-to-FPGA PIO command decoder: opcodes, PIO byte fields,
// status byte layout and FSM encoding.
package soc_h2f_cmd_pkg;

   localparam logic [2:0] OP_CLR   = 3'b111;
   localparam logic [2:0] OP_FLUSH = 3'b110;

   localparam int PIO_TOG_BIT = 7;
   localparam int PIO_OP_MSB  = 6;
   localparam int PIO_OP_LSB  = 4;
   localparam int PIO_ARG_MSB = 3;
   localparam int PIO_ARG_LSB = 0;

   localparam int STS_ACK_BIT   = 7;
   localparam int STS_OVF_BIT   = 6;
   localparam int STS_FULL_BIT  = 5;
   localparam int STS_EMPTY_BIT = 4;
   localparam int STS_LVL_MSB   = 2;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_CAPTURE = 1'b1
   } state_t;

   function automatic logic [7:0] pack_status(
      input logic       ack,
      input logic       ovf,
      input logic       full,
      input logic       empty,
      input logic [2:0] level
   );
      logic [7:0] v;
      v                     = 8'h00;
      v[STS_ACK_BIT]        = ack;
      v[STS_OVF_BIT]        = ovf;
      v[STS_FULL_BIT]       = full;
      v[STS_EMPTY_BIT]      = empty;
      v[STS_LVL_MSB:0]      = level;
      return v;
   endfunction

endpackage

// File: rtl/soc_h2f_cmd_fifo.sv
// Small command FIFO (DEPTH = 2 or 4, 7-bit entries) with flush; full is judged before
// any same-cycle pop, and flush overrides both push and pop.
module soc_h2f_cmd_fifo
   import soc_h2f_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  logic [6:0] i_data,
   output logic [6:0] o_data,
   output logic       o_full,
   output logic       o_empty,
   output logic [2:0] o_level
);

   localparam int             AW       = (DEPTH > 2) ? 2 : 1;
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [2:0]     FULL_LVL = 3'(DEPTH);

   logic [6:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [2:0]    r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_level == FULL_LVL);
   assign o_empty   = (r_level == 3'd0);
   assign o_level   = r_level;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= 3'd0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= 3'd0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 3'd1;
            2'b01:   r_level <= r_level - 3'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // entry storage, cleared on reset so the head reads as zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 7'd0;
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/soc_h2f_cmd_decoder.sv
// Synchronises the HPS PIO command byte, detects new commands by toggle change, queues
// them for fabric consumers and reports ack/overflow/FIFO state back to software.
module soc_h2f_cmd_decoder
   import soc_h2f_cmd_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] pio_in,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [2:0] cmd_opcode,
   output logic [3:0] cmd_operand,
   output logic [7:0] status
);

   logic [7:0] r_sync [SYNC_STAGES];
   state_t     r_state;
   logic       r_tog_prev;
   logic       r_ack_tog;
   logic       r_overflow;

   logic [7:0] w_sync;
   logic [2:0] w_opcode;
   logic       w_capture;
   logic       w_is_clr;
   logic       w_is_flush;
   logic       w_push;
   logic       w_flush;
   logic       w_pop;
   logic [6:0] w_head;
   logic       w_full;
   logic       w_empty;
   logic [2:0] w_level;

   // multi-flop synchroniser on the whole PIO byte
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 8'h00;
      end else begin
         r_sync[0] <= pio_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_opcode   = w_sync[PIO_OP_MSB:PIO_OP_LSB];
   assign w_capture  = (r_state == S_CAPTURE);
   assign w_is_clr   = (w_opcode == OP_CLR);
   assign w_is_flush = (w_opcode == OP_FLUSH);
   assign w_push     = w_capture && !w_is_clr && !w_is_flush;
   assign w_flush    = w_capture && w_is_flush;
   assign w_pop      = !w_empty && cmd_ready;

   // command FSM: the CAPTURE cycle lets payload bits settle behind the toggle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_tog_prev <= 1'b0;
         r_ack_tog  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sync[PIO_TOG_BIT] != r_tog_prev) begin
                  r_state    <= S_CAPTURE;
                  r_tog_prev <= w_sync[PIO_TOG_BIT];
               end
            end
            S_CAPTURE: begin
               r_ack_tog <= ~r_ack_tog;
               if (w_is_clr)
                  r_overflow <= 1'b0;
               else if (w_push && w_full)
                  r_overflow <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   soc_h2f_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_sync[PIO_OP_MSB:PIO_ARG_LSB]),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign cmd_valid   = !w_empty;
   assign cmd_opcode  = w_head[6:4];
   assign cmd_operand = w_head[PIO_ARG_MSB:PIO_ARG_LSB];
   assign status      = pack_status(r_ack_tog, r_overflow, w_full, w_empty, w_level);

endmodule
